alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Multi-cycle sequencer on the operand/op side of the 4-bit ALU.
- Drives the ALU's A, B, Op and c_in.
- Consumes R and the zero/carry/sign flags.
- Keeps an accumulator and a flag register.
- Executes single ALU ops, loads, and a 4x4->8 shift-add multiply built from repeated ALU adds.
- The ALU is instantiated beside this block, not inside it. Commands arrive on a valid/ready handshake; completion is a one-cycle pulse.

Parameters:
W, 4, datapath width; only 4 is supported, because it is fixed by the ALU.
MUL_ITERS, 4, multiply iterations; must equal W.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  command valid.
in_ready  out  1  block can accept a command; high only in IDLE.
in_cmd  in  2  command: 00 LOAD, 01 EXEC, 10 MUL, 11 NOP.
in_op  in  3  ALU Op for EXEC.
in_cin  in  1  ALU c_in for EXEC.
in_data  in  4  operand.
alu_a  out  4  to ALU A.
alu_b  out  4  to ALU B.
alu_op  out  3  to ALU Op.
alu_cin  out  1  to ALU c_in.
alu_r  in  4  from ALU R.
alu_zero, alu_carry, alu_sign  in  1 each  from the ALU flags.
acc  out  4  accumulator; holds the product high nibble after MUL.
acc_lo  out  4  product low nibble.
flag_zero, flag_carry, flag_sign  out  1 each  registered flags.
out_valid  out  1  one-cycle completion pulse.

Behaviour:
- Reset: when rst_n=0, all registers clear asynchronously: acc=0, acc_lo=0, all flags=0, out_valid=0, state=IDLE. Reset mid-operation aborts the operation and no out_valid follows.
- States: IDLE, EXEC, MUL, DONE.
- Accept: a command is accepted on the edge ending cycle C when in_valid=1 and in_ready=1. At that edge the block latches cmd, op, cin and data.
- IDLE -> EXEC for LOAD, EXEC and NOP; IDLE -> MUL for MUL.
- EXEC lasts 1 cycle (C+1), then DONE.
- MUL lasts 4 cycles (C+1..C+4), then DONE.
- DONE lasts 1 cycle with out_valid=1, then IDLE. There is no output backpressure.
- Latency: out_valid rises in C+2 for LOAD/EXEC/NOP and in C+5 for MUL. in_ready is high again in C+3 or C+6 respectively.
- in_valid held high while busy has no effect; no command is ever dropped or duplicated.
- ALU drive in IDLE and DONE: alu_a=acc, alu_b=0, alu_op=OP_ADD, alu_cin=0.
- ALU drive in EXEC: alu_a=acc, alu_b=data, alu_op=op, alu_cin=cin.
- ALU drive in MUL: alu_a=hi (the acc register), alu_b=M, alu_op=OP_ADD, alu_cin=0.
- LOAD, captured at the end of EXEC: acc<=data; zero<=(data==0); sign<=data[3]; carry unchanged; acc_lo unchanged.
- EXEC, captured at the end of EXEC: acc<=alu_r; zero/carry/sign <= ALU flags; acc_lo unchanged.
- NOP: no register changes; out_valid still pulses.
- MUL setup at accept: M<=acc (multiplicand), Q (the acc_lo register) <=data (multiplier), hi<=0, iteration counter<=0.
- MUL, each iteration:
  - If Q[0]=1: s=alu_r, co=alu_carry. Otherwise: s=hi, co=0.
  - Then hi<={co,s[3:1]}, Q<={s[0],Q[3:1]}, counter<=counter+1.
  - The 2-bit counter wraps 3->0 on the 4th iteration, and that wrap triggers MUL->DONE.
- MUL result: acc:acc_lo = 8-bit product, unsigned. At DONE entry: zero<=(product==0); sign<=acc[3]; carry<=0.
- Flags are never updated outside these rules.

Decomposition:
- Package alu_seq_pkg holds:
  - command codes CMD_LOAD=2'b00, CMD_EXEC=2'b01, CMD_MUL=2'b10, CMD_NOP=2'b11;
  - state encoding S_IDLE, S_EXEC, S_MUL, S_DONE;
  - OP_ADD=3'b000, the ALU op that gives A+B+c_in on the adder path.
- One combinational sub-module, mul_step: inputs hi, Q, alu_r, alu_carry; outputs next hi and next Q.
- The bench instantiates the real ALU alongside alu_seq.

Test Plan:
1. LOAD 4'h5 -> out_valid at C+2; acc=5, zero=0, sign=0, carry unchanged (0 after reset).
2. LOAD 5, then EXEC OP_ADD cin=0 data=3 -> acc=4'h8, sign=1, carry=0, zero=0. Then LOAD F, EXEC OP_ADD data=1 -> acc=0, zero=1, carry=1.
3. LOAD F, MUL data=F -> out_valid exactly at C+5; acc=4'hE, acc_lo=4'h1 (225), sign=1, zero=0, carry=0. Also LOAD 3, MUL 5 -> acc=0, acc_lo=F.
4. LOAD 7, MUL data=0 -> acc=0, acc_lo=0, zero=1.
5. in_valid held high with back-to-back LOAD 1 then LOAD 2 -> in_ready=0 during C+1..C+2; the second command is accepted at the end of C+3; exactly two out_valid pulses; final acc=2.
6. Assert rst_n=0 during the 2nd MUL iteration -> all outputs 0 immediately; no out_valid; after release, in_ready=1 and a LOAD 9 completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared command codes, FSM states and ALU opcode used by the alu_seq sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_EXEC = 2'b01;
  localparam logic [1:0] CMD_MUL  = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  // ALU op selecting A + B + c_in on the adder path
  localparam logic [2:0] OP_ADD = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply iteration: conditionally take the ALU sum, then shift
// the {hi, Q} pair right by one with the adder carry entering at the top.
module mul_step
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] hi,
  input  logic [W-1:0] q,
  input  logic [W-1:0] alu_r,
  input  logic         alu_carry,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] q_next
);

  logic [W-1:0] s;
  logic         co;

  always_comb begin
    s       = q[0] ? alu_r : hi;
    co      = q[0] & alu_carry;
    hi_next = {co, s[W-1:1]};
    q_next  = {s[0], q[W-1:1]};
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle operand sequencer for an external 4-bit ALU: loads, single ALU ops
// and a 4x4->8 unsigned shift-add multiply, with accumulator and flag registers.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned MUL_ITERS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_cmd,
  input  logic [2:0]   in_op,
  input  logic         in_cin,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero,
  input  logic         alu_carry,
  input  logic         alu_sign,
  output logic [W-1:0] acc,
  output logic [W-1:0] acc_lo,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         flag_sign,
  output logic         out_valid
);

  localparam logic [1:0] LAST_ITER = 2'(MUL_ITERS - 1);

  state_t       state_q, state_d;
  logic [1:0]   cmd_q, cmd_d;
  logic [2:0]   op_q, op_d;
  logic         cin_q, cin_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] m_q, m_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] acc_lo_q, acc_lo_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         sign_q, sign_d;

  logic [W-1:0] hi_next, q_next;

  // acc doubles as the product high half and acc_lo as the multiplier shift register
  mul_step #(
    .W (W)
  ) u_mul_step (
    .hi        (acc_q),
    .q         (acc_lo_q),
    .alu_r     (alu_r),
    .alu_carry (alu_carry),
    .hi_next   (hi_next),
    .q_next    (q_next)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    op_d      = op_q;
    cin_d     = cin_q;
    data_d    = data_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_lo_d  = acc_lo_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    sign_d    = sign_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = acc_q;
    alu_b     = '0;
    alu_op    = OP_ADD;
    alu_cin   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cmd_d  = in_cmd;
          op_d   = in_op;
          cin_d  = in_cin;
          data_d = in_data;
          if (in_cmd == CMD_MUL) begin
            m_d      = acc_q;
            acc_lo_d = in_data;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_b   = data_q;
        alu_op  = op_q;
        alu_cin = cin_q;
        state_d = S_DONE;
        case (cmd_q)
          CMD_LOAD: begin
            acc_d  = data_q;
            zero_d = (data_q == '0);
            sign_d = data_q[W-1];
          end
          CMD_EXEC: begin
            acc_d   = alu_r;
            zero_d  = alu_zero;
            carry_d = alu_carry;
            sign_d  = alu_sign;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        alu_b    = m_q;
        acc_d    = hi_next;
        acc_lo_d = q_next;
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          zero_d  = ({hi_next, q_next} == '0);
          sign_d  = hi_next[W-1];
          carry_d = 1'b0;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_LOAD;
      op_q     <= OP_ADD;
      cin_q    <= 1'b0;
      data_q   <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      acc_lo_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      data_q   <= data_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      acc_lo_q <= acc_lo_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
    end
  end

  assign acc        = acc_q;
  assign acc_lo     = acc_lo_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_sign  = sign_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural ALU beside it and a cycle-level model of
// command acceptance, completion timing and architectural results.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_cmd;
  logic [2:0] in_op;
  logic       in_cin;
  logic [3:0] in_data;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  logic       alu_cin, alu_zero, alu_carry, alu_sign;
  logic [3:0] acc, acc_lo;
  logic       flag_zero, flag_carry, flag_sign, out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .W         (4),
    .MUL_ITERS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_op      (in_op),
    .in_cin     (in_cin),
    .in_data    (in_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign),
    .acc        (acc),
    .acc_lo     (acc_lo),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_sign  (flag_sign),
    .out_valid  (out_valid)
  );

  // Returns {carry, r} of the 4-bit ALU
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic cin);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, cin};
      3'd6:    return {a[0], cin, a[3:1]};
      default: return {1'b0, b};
    endcase
  endfunction

  always_comb begin
    {alu_carry, alu_r} = alu_ref(alu_a, alu_b, alu_op, alu_cin);
    alu_zero = (alu_r == 4'd0);
    alu_sign = alu_r[3];
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, one compare per negedge ----------------
  int         n = 0;
  int         done_at = -1;
  int         ready_at = 0;
  logic [3:0] m_acc = 4'd0, m_lo = 4'd0;
  logic       m_z = 1'b0, m_c = 1'b0, m_s = 1'b0;
  logic [3:0] p_acc, p_lo;
  logic       p_z, p_c, p_s;
  logic [7:0] prod;
  logic       exp_ready;

  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      m_acc = 4'd0; m_lo = 4'd0; m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
      done_at = -1; ready_at = 0;
    end
    exp_ready = (n >= ready_at);
    check("m_in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
    check("m_out_valid", {7'd0, out_valid}, {7'd0, n == done_at});
    if (n == done_at) begin
      m_acc = p_acc; m_lo = p_lo; m_z = p_z; m_c = p_c; m_s = p_s;
    end
    if (exp_ready || n == done_at) begin
      check("m_acc", {4'd0, acc}, {4'd0, m_acc});
      check("m_acc_lo", {4'd0, acc_lo}, {4'd0, m_lo});
      check("m_flags", {5'd0, flag_zero, flag_carry, flag_sign}, {5'd0, m_z, m_c, m_s});
      check("m_alu_drive", {alu_b, alu_op, alu_cin}, {4'd0, OP_ADD, 1'b0});
      check("m_alu_a", {4'd0, alu_a}, {4'd0, m_acc});
    end
    if (rst_n && exp_ready && in_valid) begin
      p_acc = m_acc; p_lo = m_lo; p_z = m_z; p_c = m_c; p_s = m_s;
      case (in_cmd)
        CMD_LOAD: begin
          p_acc = in_data; p_z = (in_data == 4'd0); p_s = in_data[3];
        end
        CMD_EXEC: begin
          {p_c, p_acc} = alu_ref(m_acc, in_data, in_op, in_cin);
          p_z = (p_acc == 4'd0); p_s = p_acc[3];
        end
        CMD_MUL: begin
          prod = 8'(m_acc) * 8'(in_data);
          p_acc = prod[7:4]; p_lo = prod[3:0];
          p_z = (prod == 8'd0); p_s = prod[7]; p_c = 1'b0;
        end
        default: ;
      endcase
      done_at  = n + ((in_cmd == CMD_MUL) ? 5 : 2);
      ready_at = done_at + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] cmd, input logic [2:0] op, input logic cin,
                      input logic [3:0] data);
    int k = 0;
    forever begin
      @(posedge clk); #1;
      if (in_ready) break;
      k++;
      if (k > 20) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1");
        return;
      end
    end
    in_valid = 1'b1; in_cmd = cmd; in_op = op; in_cin = cin; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cmd = 2'($urandom); in_op = 3'($urandom); in_data = 4'($urandom);
  endtask

  // Latency counted from the accepting edge: 1 = first cycle after acceptance
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL done_timeout: out_valid never rose, required a pulse");
  endtask

  task automatic check_res(input string name, input logic [3:0] e_acc, input logic [3:0] e_lo,
                           input logic e_z, input logic e_c, input logic e_s);
    check({name, "_acc"}, {4'd0, acc}, {4'd0, e_acc});
    check({name, "_lo"}, {4'd0, acc_lo}, {4'd0, e_lo});
    check({name, "_zcs"}, {5'd0, flag_zero, flag_carry, flag_sign}, {5'd0, e_z, e_c, e_s});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    rst_n = 1'b1; in_valid = 1'b0; in_cmd = CMD_NOP; in_op = 3'd0; in_cin = 1'b0;
    in_data = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    check_res("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset_valid_ready", {6'd0, out_valid, in_ready}, 8'h01);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: load
    send(CMD_LOAD, 3'd0, 1'b0, 4'h5); wait_done(lat);
    check("t1_lat", 8'(lat), 8'd2);
    check_res("t1", 4'h5, 4'h0, 1'b0, 1'b0, 1'b0);

    // 2: exec add
    send(CMD_EXEC, OP_ADD, 1'b0, 4'h3); wait_done(lat);
    check_res("t2a", 4'h8, 4'h0, 1'b0, 1'b0, 1'b1);
    send(CMD_LOAD, 3'd0, 1'b0, 4'hF); wait_done(lat);
    send(CMD_EXEC, OP_ADD, 1'b0, 4'h1); wait_done(lat);
    check_res("t2b", 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);

    // 3: multiply 15*15 and 3*5
    send(CMD_LOAD, 3'd0, 1'b0, 4'hF); wait_done(lat);
    send(CMD_MUL, 3'd0, 1'b0, 4'hF); wait_done(lat);
    check("t3_lat", 8'(lat), 8'd5);
    check_res("t3a", 4'hE, 4'h1, 1'b0, 1'b0, 1'b1);
    send(CMD_LOAD, 3'd0, 1'b0, 4'h3); wait_done(lat);
    send(CMD_MUL, 3'd0, 1'b0, 4'h5); wait_done(lat);
    check_res("t3b", 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);

    // 4: multiply by zero
    send(CMD_LOAD, 3'd0, 1'b0, 4'h7); wait_done(lat);
    send(CMD_MUL, 3'd0, 1'b0, 4'h0); wait_done(lat);
    check_res("t4", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // 5: in_valid held high across two loads
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; in_cmd = CMD_LOAD; in_data = 4'h1;
    @(posedge clk); #1;
    in_data = 4'h2;
    check("t5_busy_c1", {7'd0, in_ready}, 8'd0);
    @(posedge clk); #1;
    check("t5_busy_c2", {7'd0, in_ready}, 8'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (i == 1) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    check("t5_pulses", 8'(pulses), 8'd2);
    check("t5_acc", {4'd0, acc}, 8'h02);

    // 6: reset during the second multiply iteration
    send(CMD_LOAD, 3'd0, 1'b0, 4'h3); wait_done(lat);
    send(CMD_MUL, 3'd0, 1'b0, 4'h5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_res("t6_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("t6_valid_ready", {6'd0, out_valid, in_ready}, 8'h01);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("t6_no_pulse", 8'(pulses), 8'd0);
    send(CMD_LOAD, 3'd0, 1'b0, 4'h9); wait_done(lat);
    check("t6_lat", 8'(lat), 8'd2);
    check_res("t6_load", 4'h9, 4'h0, 1'b0, 1'b0, 1'b1);

    // random commands, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      send(2'($urandom), 3'($urandom), 1'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
